// File: rtl/cr16_controller.sv
// Multi-cycle instruction sequencer for the CR16 datapath: fetch, decode,
// execute and writeback of RR, Immediate, MOVI and conditional branch words.
module cr16_controller (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_INSTR,
  input  logic        I_INSTR_VALID,
  input  logic [4:0]  I_FLAGS,
  output logic        O_MEM_REQ,
  output logic [15:0] O_PC,
  output logic [15:0] O_REG_ENABLE,
  output logic [3:0]  O_OPCODE,
  output logic [3:0]  O_READ_PORT_A_SEL,
  output logic [3:0]  O_READ_PORT_B_SEL,
  output logic [15:0] O_IMMEDIATE,
  output logic        O_IMM_SEL,
  output logic [1:0]  O_DBG_STATE
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_RR     = 4'b0000;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_MOVI   = 4'b1101;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        mem_req_q;
  logic [15:0] reg_en_q;
  logic        branch_taken;
  logic        unused_flags;

  // Fetch handshake: O_MEM_REQ is the ready, I_INSTR_VALID the valid; a word
  // transfers only on an enabled rising edge where both are high.
  assign O_MEM_REQ    = mem_req_q & I_ENABLE & I_NRESET;
  // Gating by reset means a reset landing on WRITEBACK never writes.
  assign O_REG_ENABLE = reg_en_q & {16{I_ENABLE & I_NRESET}};
  assign O_PC         = pc;
  assign O_DBG_STATE  = state;
  assign unused_flags = I_FLAGS[4] ^ I_FLAGS[2];

  always_comb begin
    branch_taken = 1'b0;
    case (ir[11:8])
      4'b0000: branch_taken = I_FLAGS[3];
      4'b0001: branch_taken = ~I_FLAGS[3];
      4'b0010: branch_taken = I_FLAGS[0];
      4'b0011: branch_taken = ~I_FLAGS[0];
      4'b0100: branch_taken = I_FLAGS[1];
      4'b0101: branch_taken = ~I_FLAGS[1];
      4'b1110: branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state             <= FETCH;
      pc                <= 16'h0000;
      ir                <= 16'h0000;
      mem_req_q         <= 1'b0;
      reg_en_q          <= 16'h0000;
      O_OPCODE          <= 4'h0;
      O_READ_PORT_A_SEL <= 4'h0;
      O_READ_PORT_B_SEL <= 4'h0;
      O_IMMEDIATE       <= 16'h0000;
      O_IMM_SEL         <= 1'b0;
    end else if (I_ENABLE) begin
      case (state)
        FETCH: begin
          if (mem_req_q && I_INSTR_VALID) begin
            ir        <= I_INSTR;
            mem_req_q <= 1'b0;
            state     <= DECODE;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        DECODE: begin
          if (ir[15:12] == OP_RR) begin
            O_OPCODE          <= ir[7:4];
            O_READ_PORT_A_SEL <= ir[11:8];
            O_READ_PORT_B_SEL <= ir[3:0];
            O_IMMEDIATE       <= 16'h0000;
            O_IMM_SEL         <= 1'b0;
          end else if (ir[15:12] == OP_BCOND) begin
            O_OPCODE          <= 4'h0;
            O_READ_PORT_A_SEL <= 4'h0;
            O_READ_PORT_B_SEL <= 4'h0;
            O_IMMEDIATE       <= 16'h0000;
            O_IMM_SEL         <= 1'b0;
          end else if (ir[15:12] == OP_MOVI) begin
            O_OPCODE          <= 4'h0;
            O_READ_PORT_A_SEL <= ir[11:8];
            O_READ_PORT_B_SEL <= 4'h0;
            O_IMMEDIATE       <= {8'h00, ir[7:0]};
            O_IMM_SEL         <= 1'b1;
          end else begin
            O_OPCODE          <= ir[15:12];
            O_READ_PORT_A_SEL <= ir[11:8];
            O_READ_PORT_B_SEL <= 4'h0;
            O_IMMEDIATE       <= {{8{ir[7]}}, ir[7:0]};
            O_IMM_SEL         <= 1'b1;
          end
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (ir[15:12] == OP_BCOND) begin
            pc        <= branch_taken ? pc + {{8{ir[7]}}, ir[7:0]} : pc + 16'd1;
            mem_req_q <= 1'b1;
            state     <= FETCH;
          end else begin
            reg_en_q <= 16'd1 << ir[11:8];
            state    <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          reg_en_q  <= 16'h0000;
          pc        <= pc + 16'd1;
          mem_req_q <= 1'b1;
          state     <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cr16_controller.sv
// Directed bench for cr16_controller: reset, RR/MOVI/Immediate execution,
// branch conditions, stall/enable behaviour, PC wrap and reset during writeback.
module tb_cr16_controller;

  logic        clk;
  logic        nreset;
  logic        enable;
  logic [15:0] instr;
  logic        instr_valid;
  logic [4:0]  flags;
  logic        mem_req;
  logic [15:0] pc;
  logic [15:0] reg_enable;
  logic [3:0]  opcode;
  logic [3:0]  a_sel;
  logic [3:0]  b_sel;
  logic [15:0] immediate;
  logic        imm_sel;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  cr16_controller dut (
    .I_CLK             (clk),
    .I_NRESET          (nreset),
    .I_ENABLE          (enable),
    .I_INSTR           (instr),
    .I_INSTR_VALID     (instr_valid),
    .I_FLAGS           (flags),
    .O_MEM_REQ         (mem_req),
    .O_PC              (pc),
    .O_REG_ENABLE      (reg_enable),
    .O_OPCODE          (opcode),
    .O_READ_PORT_A_SEL (a_sel),
    .O_READ_PORT_B_SEL (b_sel),
    .O_IMMEDIATE       (immediate),
    .O_IMM_SEL         (imm_sel),
    .O_DBG_STATE       (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    nreset = 1'b0; enable = 1'b0; instr_valid = 1'b0; instr = 16'h0000; flags = 5'b0;
    tick();
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    enable = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL reset_reg_en got %h exp 0000", reg_enable); end
    checks++; if ({opcode, a_sel, b_sel, immediate, imm_sel} !== 29'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {opcode, a_sel, b_sel, immediate, imm_sel});
    end
    nreset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL first_req_pc got %h exp 0000", pc); end
  endtask

  task automatic test_rr();
    instr = 16'h0201; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_decode_req got %b exp 0", mem_req); end
    checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL rr_decode_wen got %h exp 0000", reg_enable); end
    tick();
    checks++; if (a_sel !== 4'd2) begin errors++; $display("FAIL rr_a_sel got %0d exp 2", a_sel); end
    checks++; if (b_sel !== 4'd1) begin errors++; $display("FAIL rr_b_sel got %0d exp 1", b_sel); end
    checks++; if (opcode !== 4'd0) begin errors++; $display("FAIL rr_opcode got %0d exp 0", opcode); end
    checks++; if (imm_sel !== 1'b0) begin errors++; $display("FAIL rr_imm_sel got %b exp 0", imm_sel); end
    checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL rr_exec_wen got %h exp 0000", reg_enable); end
    tick();
    checks++; if (reg_enable !== 16'h0004) begin errors++; $display("FAIL rr_wb_wen got %h exp 0004", reg_enable); end
    tick();
    checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL rr_after_wen got %h exp 0000", reg_enable); end
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL rr_pc got %h exp 0001", pc); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rr_req got %b exp 1", mem_req); end
  endtask

  task automatic test_movi_imm();
    instr = 16'hD3FF; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    checks++; if (immediate !== 16'h00FF) begin errors++; $display("FAIL movi_imm got %h exp 00ff", immediate); end
    checks++; if (imm_sel !== 1'b1) begin errors++; $display("FAIL movi_imm_sel got %b exp 1", imm_sel); end
    checks++; if (opcode !== 4'd0) begin errors++; $display("FAIL movi_opcode got %0d exp 0", opcode); end
    checks++; if (a_sel !== 4'd3 || b_sel !== 4'd0) begin errors++; $display("FAIL movi_sel got %0d/%0d exp 3/0", a_sel, b_sel); end
    tick();
    checks++; if (reg_enable !== 16'h0008) begin errors++; $display("FAIL movi_wen got %h exp 0008", reg_enable); end
    tick();
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL movi_pc got %h exp 0002", pc); end
    instr = 16'h53FF; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    checks++; if (immediate !== 16'hFFFF) begin errors++; $display("FAIL imm_sext got %h exp ffff", immediate); end
    checks++; if (opcode !== 4'd5) begin errors++; $display("FAIL imm_opcode got %0d exp 5", opcode); end
    checks++; if (imm_sel !== 1'b1) begin errors++; $display("FAIL imm_imm_sel got %b exp 1", imm_sel); end
    tick();
    checks++; if (reg_enable !== 16'h0008) begin errors++; $display("FAIL imm_wen got %h exp 0008", reg_enable); end
    tick();
    checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL imm_pc got %h exp 0003", pc); end
  endtask

  task automatic test_branch();
    logic [15:0] b_instr [8];
    logic [4:0]  b_flags [8];
    logic [15:0] b_pc    [8];
    // PC starts at 0003; each row is a branch and the PC it must leave behind.
    b_instr = '{16'hCE0D, 16'hC0FE, 16'hCE02, 16'hC0FE, 16'hC7FE, 16'hC205, 16'hC405, 16'hC505};
    b_flags = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b11111, 5'b00001, 5'b00010, 5'b00010};
    b_pc    = '{16'h0010, 16'h000E, 16'h0010, 16'h0011, 16'h0012, 16'h0017, 16'h001C, 16'h001D};
    for (int i = 0; i < 8; i++) begin
      instr = b_instr[i]; flags = b_flags[i]; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL br%0d_decode_wen got %h exp 0000", i, reg_enable); end
      tick();
      checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL br%0d_exec_wen got %h exp 0000", i, reg_enable); end
      tick();
      checks++; if (pc !== b_pc[i]) begin errors++; $display("FAIL br%0d_pc got %h exp %h", i, pc, b_pc[i]); end
      checks++; if (mem_req !== 1'b1 || dbg_state !== 2'd0) begin
        errors++; $display("FAIL br%0d_fetch got req=%b st=%0d exp req=1 st=0", i, mem_req, dbg_state);
      end
    end
    flags = 5'b0;
  endtask

  task automatic test_stall();
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || pc !== 16'h001D || dbg_state !== 2'd0) begin
        errors++; $display("FAIL stall%0d got req=%b pc=%h st=%0d exp req=1 pc=001d st=0", i, mem_req, pc, dbg_state);
      end
    end
    // A valid word offered while disabled must not be taken.
    enable = 1'b0; instr = 16'h0101; instr_valid = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL dis_fetch_req got %b exp 0", mem_req); end
    tick();
    tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL dis_no_capture got st=%0d exp 0", dbg_state); end
    instr_valid = 1'b0; enable = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL dis_resume got req=%b st=%0d exp req=1 st=0", mem_req, dbg_state);
    end
    instr = 16'h0A12; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL stall_exec got st=%0d exp 2", dbg_state); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dbg_state !== 2'd2 || reg_enable !== 16'h0000 || mem_req !== 1'b0) begin
        errors++; $display("FAIL hold%0d got st=%0d wen=%h req=%b exp st=2 wen=0000 req=0", i, dbg_state, reg_enable, mem_req);
      end
    end
    enable = 1'b1;
    tick();
    checks++; if (reg_enable !== 16'h0400) begin errors++; $display("FAIL stall_wen got %h exp 0400", reg_enable); end
    tick();
    checks++; if (reg_enable !== 16'h0000 || pc !== 16'h001E) begin
      errors++; $display("FAIL stall_done got wen=%h pc=%h exp wen=0000 pc=001e", reg_enable, pc);
    end
  endtask

  task automatic test_wrap();
    instr = 16'hCEE1; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_branch_pc got %h exp ffff", pc); end
    instr = 16'h0201; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    checks++; if (reg_enable !== 16'h0004) begin errors++; $display("FAIL wrap_wen got %h exp 0004", reg_enable); end
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
  endtask

  task automatic test_reset_writeback();
    instr = 16'h0305; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    checks++; if (reg_enable !== 16'h0008 || dbg_state !== 2'd3) begin
      errors++; $display("FAIL rstwb_pre got wen=%h st=%0d exp wen=0008 st=3", reg_enable, dbg_state);
    end
    nreset = 1'b0;
    #1;
    checks++; if (reg_enable !== 16'h0000) begin errors++; $display("FAIL rstwb_no_write got %h exp 0000", reg_enable); end
    tick();
    checks++; if (pc !== 16'h0000 || mem_req !== 1'b0 || dbg_state !== 2'd0 || reg_enable !== 16'h0000) begin
      errors++; $display("FAIL rstwb_reset got pc=%h req=%b st=%0d wen=%h exp pc=0000 req=0 st=0 wen=0000", pc, mem_req, dbg_state, reg_enable);
    end
    nreset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || pc !== 16'h0000) begin
      errors++; $display("FAIL rstwb_resume got req=%b pc=%h exp req=1 pc=0000", mem_req, pc);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_movi_imm();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_writeback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr16_controller.md
CR16_CONTROLLER -- requirements
Module: cr16_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: I_CLK is the single clock, I_NRESET is synchronous and active-low, and all state changes SHALL occur on the I_CLK rising edge only.
REQ-002 The block SHALL provide these ports:
- I_CLK  in  1  clock
- I_NRESET  in  1  synchronous active-low reset
- I_ENABLE  in  1  global enable; 0 freezes all state
- I_INSTR  in  16  instruction word from memory
- I_INSTR_VALID  in  1  I_INSTR valid this cycle
- I_FLAGS  in  5  datapath flags: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N
- O_MEM_REQ  out  1  instruction fetch request
- O_PC  out  16  fetch address
- O_REG_ENABLE  out  16  one-hot register write enable to datapath
- O_OPCODE  out  4  ALU opcode to datapath
- O_READ_PORT_A_SEL  out  4  register index, port A
- O_READ_PORT_B_SEL  out  4  register index, port B
- O_IMMEDIATE  out  16  immediate operand
- O_IMM_SEL  out  1  1 = datapath uses O_IMMEDIATE instead of port B

Function
REQ-003 The FSM SHALL have the states FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-004 FETCH: O_MEM_REQ=1 and O_PC=PC. On an edge with I_INSTR_VALID=1, the block SHALL capture I_INSTR into IR and move to DECODE; otherwise it SHALL stay in FETCH.
REQ-005 I_INSTR_VALID SHALL be ignored in every state other than FETCH, and O_MEM_REQ SHALL be 0 outside FETCH.
REQ-006 DECODE SHALL take exactly one cycle and SHALL register the decoded fields, then move to EXECUTE.
REQ-007 Instruction formats:
- RR: IR[15:12]=0000; Rdest=IR[11:8], opext=IR[7:4], Rsrc=IR[3:0].
- Immediate: IR[15:12] is not 0000, 1100 or 1101; Rdest=IR[11:8], imm=IR[7:0].
- Bcond: IR[15:12]=1100; cond=IR[11:8], disp=IR[7:0].
- MOVI: IR[15:12]=1101; Rdest=IR[11:8], imm=IR[7:0].
REQ-008 In EXECUTE and WRITEBACK, O_READ_PORT_A_SEL SHALL equal Rdest and O_READ_PORT_B_SEL SHALL equal Rsrc for RR, or 0 for the other formats.
REQ-009 RR: O_OPCODE=opext, O_IMM_SEL=0.
REQ-010 Immediate: O_OPCODE=IR[15:12], O_IMM_SEL=1, O_IMMEDIATE={{8{imm[7]}},imm}.
REQ-011 MOVI: O_OPCODE=0000, O_IMM_SEL=1, O_IMMEDIATE={8'h00,imm}.
REQ-012 After EXECUTE, RR, Immediate and MOVI SHALL go to WRITEBACK. WRITEBACK SHALL assert O_REG_ENABLE = 1<<Rdest for exactly one cycle, set PC=PC+1, and return to FETCH.
REQ-013 O_REG_ENABLE SHALL be 16'h0000 in every state other than WRITEBACK.
REQ-014 Bcond SHALL evaluate I_FLAGS in EXECUTE, with no WRITEBACK. Condition codes:
- 0000 EQ: Z=1
- 0001 NE: Z=0
- 0010 CS: C=1
- 0011 CC: C=0
- 0100 HI: L=1
- 0101 LS: L=0
- 1110 UC: always taken
- all other codes: never taken
REQ-015 On a taken branch, PC SHALL become PC+{{8{disp[7]}},disp}; otherwise PC+1. In both cases the next state SHALL be FETCH.
REQ-016 PC arithmetic SHALL be modulo 2^16; 16'hFFFF+1 SHALL equal 16'h0000.
REQ-017 Latency: an RR, Immediate or MOVI instruction SHALL take 4 cycles when I_INSTR_VALID is high on the first FETCH cycle; a Bcond SHALL take 3 cycles.
REQ-018 When I_ENABLE=0, the FSM, PC and IR SHALL hold, and O_REG_ENABLE and O_MEM_REQ SHALL be forced to 0. When I_ENABLE returns to 1, the block SHALL resume in the held state.
REQ-019 A FETCH edge with I_ENABLE=0 and I_INSTR_VALID=1 SHALL NOT capture the instruction.

Reset
REQ-020 An I_CLK edge with I_NRESET=0 SHALL force: state=FETCH, PC=0, IR=0, and all outputs to 0, including O_MEM_REQ=0 for that cycle. Reset SHALL override I_ENABLE.
REQ-021 The first O_MEM_REQ=1 with O_PC=0 SHALL appear on the cycle after I_NRESET is sampled high.
REQ-022 A reset asserted mid-instruction, including during WRITEBACK, SHALL abort the instruction with no register write on that edge.

Verification
REQ-023 RR: I_INSTR=16'h0201 (Rdest=2, opext=0, Rsrc=1), valid immediately -> O_READ_PORT_A_SEL=2, O_READ_PORT_B_SEL=1, O_OPCODE=0; O_REG_ENABLE=16'h0004 for exactly one cycle, 3 cycles after capture; then O_PC=1.
REQ-024 MOVI/Immediate: 16'hD3FF -> O_IMMEDIATE=16'h00FF, O_IMM_SEL=1, O_REG_ENABLE=16'h0008. Then 16'h53FF -> O_IMMEDIATE=16'hFFFF, O_OPCODE=5.
REQ-025 Branch: PC=16'h0010, 16'hC0FE with I_FLAGS[3]=1 -> next O_PC=16'h000E. The same instruction with Z=0 -> 16'h0011. 16'hC7xx -> never taken. O_REG_ENABLE stays 0 throughout.
REQ-026 Handshake/stall: hold I_INSTR_VALID=0 for 5 cycles -> O_MEM_REQ stays 1, O_PC stable, no state change. Drop I_ENABLE for 3 cycles during EXECUTE -> the instruction completes later with a single write.
REQ-027 Wrap and reset: a UC branch to 16'hFFFF followed by an RR instruction -> O_PC=16'h0000. Assert I_NRESET=0 during WRITEBACK -> no write, O_PC=0, O_MEM_REQ=0 that cycle, then 1.
